// File: rtl/address_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : address_sequencer
// Description : Bus-cycle phase counter plus per-addressing-mode address step
//               sequencer. Every bus cycle (step) is four fclk long; sequencing
//               decisions are taken at the step boundary (the edge ending
//               q == 3). Each step drives a pair of address-byte source codes
//               and, in its q == 3 fclk, one-cycle strobes.
// Ports       : fclk          - sole clock, rising edge
//               resb          - synchronous active-low reset
//               start/amode   - sequence request and its addressing mode
//               rdy           - low at q == 3 repeats the current step
//               q, phi2       - phase counter, phi2 = q[1]
//               hmode_select  - high address byte source code
//               lmode_select  - low address byte source code
//               pc_inc, latch_a_en, latch_b_en, alu_add_req, alu_idx
//                             - step strobes (alu_idx: 0 = X, 1 = Y)
//               start_ack, done, busy, bad_mode - handshake / status
// Revision    : 1.0 - initial release
// ============================================================================
module address_sequencer (
  input  logic       fclk,
  input  logic       resb,
  input  logic       start,
  input  logic [2:0] amode,
  input  logic       rdy,
  output logic [1:0] q,
  output logic       phi2,
  output logic [2:0] hmode_select,
  output logic [2:0] lmode_select,
  output logic       pc_inc,
  output logic       latch_a_en,
  output logic       latch_b_en,
  output logic       alu_add_req,
  output logic       alu_idx,
  output logic       start_ack,
  output logic       done,
  output logic       busy,
  output logic       bad_mode
);

  // Sequencer states: IDLE or the index of the step in progress.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_S0   = 2'd1;
  localparam logic [1:0] ST_S1   = 2'd2;
  localparam logic [1:0] ST_S2   = 2'd3;

  // Addressing modes.
  localparam logic [2:0] M_FETCH = 3'd0;
  localparam logic [2:0] M_ZP    = 3'd1;
  localparam logic [2:0] M_ZPX   = 3'd2;
  localparam logic [2:0] M_ABS   = 3'd3;
  localparam logic [2:0] M_ABSX  = 3'd4;
  localparam logic [2:0] M_ABSY  = 3'd5;
  localparam logic [2:0] M_STACK = 3'd6;
  localparam logic [2:0] M_BAD   = 3'd7;

  // Address byte source codes.
  localparam logic [2:0] H_PCH  = 3'b101;
  localparam logic [2:0] H_LA   = 3'b110;
  localparam logic [2:0] H_P01  = 3'b010;
  localparam logic [2:0] H_P00  = 3'b000;
  localparam logic [2:0] L_PCL  = 3'b101;
  localparam logic [2:0] L_LB   = 3'b110;
  localparam logic [2:0] L_SP   = 3'b010;
  localparam logic [2:0] L_ALU  = 3'b011;

  logic [1:0] r_q;
  logic [1:0] r_state;
  logic [2:0] r_mode;

  logic       w_adv;
  logic       w_last;
  logic       w_free;
  logic       w_take;
  logic [2:0] w_h;
  logic [2:0] w_l;
  logic       w_pc;
  logic       w_la;
  logic       w_lb;
  logic       w_alu;

  // A step only advances at the boundary with rdy high; reset in the same
  // cycle cancels any pulse so an aborted sequence never reports done.
  assign w_adv = (r_q == 2'd3) && rdy && resb;

  always_comb begin
    w_last = 1'b0;
    case (r_mode)
      M_FETCH, M_STACK: w_last = (r_state == ST_S0);
      M_ZP, M_ZPX:      w_last = (r_state == ST_S1);
      default:          w_last = (r_state == ST_S2);
    endcase
  end

  // A new request may be taken from IDLE or overlapped with the last step.
  assign w_free = (r_state == ST_IDLE) || w_last;
  assign w_take = w_adv && w_free && start;

  // Per-step select codes (held for the whole step) and strobe enables.
  always_comb begin
    w_h   = H_PCH;
    w_l   = L_PCL;
    w_pc  = 1'b0;
    w_la  = 1'b0;
    w_lb  = 1'b0;
    w_alu = 1'b0;
    case (r_state)
      ST_S0: begin
        if (r_mode == M_STACK) begin
          w_h = H_P01;
          w_l = L_SP;
        end else begin
          w_pc = 1'b1;
          w_lb = (r_mode != M_FETCH);
        end
      end
      ST_S1: begin
        if (r_mode == M_ZP) begin
          w_h = H_P00;
          w_l = L_LB;
        end else if (r_mode == M_ZPX) begin
          w_h   = H_P00;
          w_l   = L_ALU;
          w_alu = 1'b1;
        end else begin
          w_pc = 1'b1;
          w_la = 1'b1;
        end
      end
      ST_S2: begin
        w_h = H_LA;
        if (r_mode == M_ABS) begin
          w_l = L_LB;
        end else begin
          w_l   = L_ALU;
          w_alu = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge fclk) begin
    if (!resb) begin
      r_q     <= 2'd0;
      r_state <= ST_IDLE;
      r_mode  <= M_FETCH;
    end else begin
      r_q <= r_q + 2'd1;
      if (w_adv) begin
        if (w_free) begin
          if (start && (amode != M_BAD)) begin
            r_state <= ST_S0;
            r_mode  <= amode;
          end else begin
            r_state <= ST_IDLE;
          end
        end else begin
          r_state <= r_state + 2'd1;
        end
      end
    end
  end

  assign q            = r_q;
  assign phi2         = r_q[1];
  assign hmode_select = w_h;
  assign lmode_select = w_l;
  assign busy         = (r_state != ST_IDLE);
  assign pc_inc       = w_adv && w_pc;
  assign latch_a_en   = w_adv && w_la;
  assign latch_b_en   = w_adv && w_lb;
  assign alu_add_req  = w_adv && w_alu;
  assign alu_idx      = busy && (r_mode == M_ABSY);
  assign done         = w_adv && busy && w_last;
  assign start_ack    = w_take;
  assign bad_mode     = w_take && (amode == M_BAD);

endmodule
`default_nettype wire

// File: tb/tb_address_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_address_sequencer
// Description : Self-checking bench for address_sequencer. A directed table
//               covers reset and an ABS sequence; directed sequences and
//               random traffic are compared against a queue-of-steps model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_address_sequencer;

  logic       fclk;
  logic       resb;
  logic       start;
  logic [2:0] amode;
  logic       rdy;
  logic [1:0] q;
  logic       phi2;
  logic [2:0] hmode_select;
  logic [2:0] lmode_select;
  logic       pc_inc;
  logic       latch_a_en;
  logic       latch_b_en;
  logic       alu_add_req;
  logic       alu_idx;
  logic       start_ack;
  logic       done;
  logic       busy;
  logic       bad_mode;

  address_sequencer dut (
    .fclk         (fclk),
    .resb         (resb),
    .start        (start),
    .amode        (amode),
    .rdy          (rdy),
    .q            (q),
    .phi2         (phi2),
    .hmode_select (hmode_select),
    .lmode_select (lmode_select),
    .pc_inc       (pc_inc),
    .latch_a_en   (latch_a_en),
    .latch_b_en   (latch_b_en),
    .alu_add_req  (alu_add_req),
    .alu_idx      (alu_idx),
    .start_ack    (start_ack),
    .done         (done),
    .busy         (busy),
    .bad_mode     (bad_mode)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  int n_pass  = 0;
  int n_total = 0;

  // ---------------------------------------------------------------- model
  typedef struct packed {
    logic [2:0] h;
    logic [2:0] l;
    logic       pc;
    logic       la;
    logic       lb;
    logic       alu;
    logic       idx;
  } step_t;

  step_t      mq[$];      // remaining steps of the sequence in progress
  logic [1:0] mcnt;
  logic       m_adv;
  logic       m_ack;
  logic       last_ack;
  logic       last_done;

  function automatic step_t mk(input logic [2:0] h, input logic [2:0] l,
                               input logic pc, input logic la, input logic lb,
                               input logic alu, input logic idx);
    step_t s;
    s.h = h; s.l = l; s.pc = pc; s.la = la; s.lb = lb; s.alu = alu; s.idx = idx;
    return s;
  endfunction

  task automatic push_steps(input logic [2:0] am);
    logic y;
    y = (am == 3'd5);
    case (am)
      3'd0: mq.push_back(mk(3'b101, 3'b101, 1, 0, 0, 0, 0));
      3'd1: begin
        mq.push_back(mk(3'b101, 3'b101, 1, 0, 1, 0, 0));
        mq.push_back(mk(3'b000, 3'b110, 0, 0, 0, 0, 0));
      end
      3'd2: begin
        mq.push_back(mk(3'b101, 3'b101, 1, 0, 1, 0, 0));
        mq.push_back(mk(3'b000, 3'b011, 0, 0, 0, 1, 0));
      end
      3'd3: begin
        mq.push_back(mk(3'b101, 3'b101, 1, 0, 1, 0, 0));
        mq.push_back(mk(3'b101, 3'b101, 1, 1, 0, 0, 0));
        mq.push_back(mk(3'b110, 3'b110, 0, 0, 0, 0, 0));
      end
      3'd4, 3'd5: begin
        mq.push_back(mk(3'b101, 3'b101, 1, 0, 1, 0, y));
        mq.push_back(mk(3'b101, 3'b101, 1, 1, 0, 0, y));
        mq.push_back(mk(3'b110, 3'b011, 0, 0, 0, 1, y));
      end
      3'd6: mq.push_back(mk(3'b010, 3'b010, 0, 0, 0, 0, 0));
      default: ;
    endcase
  endtask

  // Packed output vector: {q, phi2, h, l, pc, la, lb, alu, idx, ack, done, busy, bad}
  function automatic logic [17:0] pk(input logic [1:0] qq, input logic [2:0] h,
                                     input logic [2:0] l, input logic pc,
                                     input logic la, input logic lb,
                                     input logic alu, input logic idx,
                                     input logic ack, input logic dn,
                                     input logic bz, input logic bad);
    return {qq, qq[1], h, l, pc, la, lb, alu, idx, ack, dn, bz, bad};
  endfunction

  function automatic logic [17:0] model_eval(input logic rb, input logic st,
                                             input logic [2:0] am, input logic rd);
    step_t f;
    logic  act;
    act   = (mq.size() > 0);
    f     = act ? mq[0] : mk(3'b101, 3'b101, 0, 0, 0, 0, 0);
    m_adv = (mcnt == 2'd3) && rd && rb;
    m_ack = m_adv && (mq.size() <= 1) && st;
    return pk(mcnt, f.h, f.l, m_adv && act && f.pc, m_adv && act && f.la,
              m_adv && act && f.lb, m_adv && act && f.alu, act && f.idx,
              m_ack, m_adv && (mq.size() == 1), act, m_ack && (am == 3'd7));
  endfunction

  task automatic model_update(input logic rb, input logic [2:0] am);
    if (!rb) begin
      mq.delete();
      mcnt = 2'd0;
    end else begin
      mcnt = mcnt + 2'd1;
      if (m_adv && (mq.size() > 0)) void'(mq.pop_front());
      if (m_ack && (am != 3'd7)) push_steps(am);
    end
  endtask

  // ---------------------------------------------------------------- checks
  task automatic check(input string nm, input logic [17:0] exp);
    logic [17:0] act;
    act = {q, phi2, hmode_select, lmode_select, pc_inc, latch_a_en, latch_b_en,
           alu_add_req, alu_idx, start_ack, done, busy, bad_mode};
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t got q=%0d phi2=%b h=%b l=%b pc/la/lb/alu/idx=%b ack/done/busy/bad=%b  want q=%0d phi2=%b h=%b l=%b pc/la/lb/alu/idx=%b ack/done/busy/bad=%b",
                  nm, $time, act[17:16], act[15], act[14:12], act[11:9], act[8:4], act[3:0],
                  exp[17:16], exp[15], exp[14:12], exp[11:9], exp[8:4], exp[3:0]);
  endtask

  // One fclk: drive inputs just after the rising edge, compare at the falling
  // edge, then advance the model with the edge.
  task automatic cyc(input logic rb, input logic st, input logic [2:0] am,
                     input logic rd, input logic use_x, input logic [17:0] xexp,
                     input string nm);
    logic [17:0] e;
    resb = rb; start = st; amode = am; rdy = rd;
    @(negedge fclk);
    e = model_eval(rb, st, am, rd);
    check(nm, use_x ? xexp : e);
    last_ack  = start_ack;
    last_done = done;
    @(posedge fclk);
    model_update(rb, am);
    #1;
  endtask

  task automatic req(input logic [2:0] am, input string nm);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      cyc(1, 1, am, 1, 0, '0, nm);
      got = last_ack;
    end
    n_total++;
    if (got) n_pass++;
    else $display("FAIL %s_ack_timeout got start_ack=0 want start_ack=1 within 8 fclk", nm);
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  am;
    logic        rd;
    logic [17:0] x;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic st, input logic [2:0] am, input logic rd,
                     input logic [1:0] qq, input logic [2:0] h, input logic [2:0] l,
                     input logic pc, input logic la, input logic lb,
                     input logic dn, input logic ack, input logic bz);
    vec_t v;
    v.st = st; v.am = am; v.rd = rd;
    v.x  = pk(qq, h, l, pc, la, lb, 1'b0, 1'b0, ack, dn, bz, 1'b0);
    tbl.push_back(v);
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    resb = 1'b0; start = 1'b0; amode = 3'd0; rdy = 1'b1;
    mcnt = 2'd0; m_adv = 1'b0; m_ack = 1'b0; last_ack = 1'b0; last_done = 1'b0;
    repeat (3) @(posedge fclk);
    #1;

    // Reset state, idle phase cycling, then ABS with mode changes mid-sequence.
    //   st am rd  q  h       l      pc la lb dn ack bz
    add(1, 3, 1, 0, 3'b101, 3'b101, 0, 0, 0, 0, 0, 0);
    add(1, 3, 1, 1, 3'b101, 3'b101, 0, 0, 0, 0, 0, 0);
    add(1, 3, 1, 2, 3'b101, 3'b101, 0, 0, 0, 0, 0, 0);
    add(1, 3, 1, 3, 3'b101, 3'b101, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0, 3'b101, 3'b101, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 1, 3'b101, 3'b101, 0, 0, 0, 0, 0, 1);
    add(0, 6, 0, 2, 3'b101, 3'b101, 0, 0, 0, 0, 0, 1);
    add(0, 6, 1, 3, 3'b101, 3'b101, 1, 0, 1, 0, 0, 1);
    add(1, 7, 1, 0, 3'b101, 3'b101, 0, 0, 0, 0, 0, 1);
    add(1, 7, 1, 1, 3'b101, 3'b101, 0, 0, 0, 0, 0, 1);
    add(0, 2, 1, 2, 3'b101, 3'b101, 0, 0, 0, 0, 0, 1);
    add(0, 2, 1, 3, 3'b101, 3'b101, 1, 1, 0, 0, 0, 1);
    add(0, 0, 1, 0, 3'b110, 3'b110, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 1, 3'b110, 3'b110, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 2, 3'b110, 3'b110, 0, 0, 0, 0, 0, 1);
    add(0, 0, 1, 3, 3'b110, 3'b110, 0, 0, 0, 1, 0, 1);
    add(0, 0, 1, 0, 3'b101, 3'b101, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < tbl.size(); i++)
      cyc(1, tbl[i].st, tbl[i].am, tbl[i].rd, 1, tbl[i].x, $sformatf("tbl_abs_row%0d", i));
    repeat (3) cyc(1, 0, 0, 1, 0, '0, "idle_tail");

    // ABSX stalled over the last step's boundary.
    req(3'd4, "absx");
    repeat (8) cyc(1, 0, 0, 1, 0, '0, "absx_s0s1");
    repeat (3) cyc(1, 0, 0, 1, 0, '0, "absx_s2");
    cyc(1, 0, 0, 0, 0, '0, "absx_s2_stall");
    repeat (4) cyc(1, 0, 0, 0, 0, '0, "absx_s2_stall2");
    repeat (4) cyc(1, 0, 0, 1, 0, '0, "absx_s2_resume");
    repeat (2) cyc(1, 0, 0, 1, 0, '0, "absx_idle");

    // ABSY: alu_idx selects Y.
    req(3'd5, "absy");
    repeat (14) cyc(1, 0, 0, 1, 0, '0, "absy_run");

    // STACK immediately followed by FETCH.
    req(3'd6, "stack");
    repeat (3) cyc(1, 0, 0, 1, 0, '0, "stack_s0");
    cyc(1, 1, 0, 1, 0, '0, "stack_b2b");
    n_total++;
    if ({last_ack, last_done} === 2'b11) n_pass++;
    else $display("FAIL b2b_ack_done got ack,done=%b want 11", {last_ack, last_done});
    repeat (8) cyc(1, 0, 0, 1, 0, '0, "fetch_after_stack");

    // Illegal mode.
    req(3'd7, "bad");
    repeat (5) cyc(1, 0, 0, 1, 0, '0, "bad_idle");

    // Reset during s1 of ZPX.
    req(3'd2, "zpx");
    repeat (5) cyc(1, 0, 0, 1, 0, '0, "zpx_to_s1");
    cyc(0, 0, 0, 1, 0, '0, "zpx_reset");
    repeat (5) cyc(1, 1, 3'd1, 1, 0, '0, "after_reset");
    repeat (8) cyc(1, 0, 0, 1, 0, '0, "after_reset_zp");

    // Random traffic.
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 63) != 0, $urandom_range(0, 1), 3'($urandom_range(0, 7)),
          $urandom_range(0, 3) != 0, 0, '0, "random");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/address_sequencer.md
ADDRESS_SEQUENCER -- requirements
Module: address_sequencer

Interface
REQ-001 SHALL have no parameters; bus-cycle length is fixed at 4 fclk periods.
REQ-002 SHALL have port fclk  in  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port resb  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  in  1  request a new address sequence; held until start_ack.
REQ-005 SHALL have port amode  in  3  addressing mode for the request, sampled with start.
REQ-006 SHALL have port rdy  in  1  high = advance; low freezes sequencing at the step boundary.
REQ-007 SHALL have port q  out  2  bus-cycle phase counter.
REQ-008 SHALL have port phi2  out  1  equals q[1].
REQ-009 SHALL have ports hmode_select and lmode_select  out  3 each  address byte source codes.
REQ-010 SHALL have ports pc_inc, latch_a_en, latch_b_en, alu_add_req  out  1 each  single-fclk strobes.
REQ-011 SHALL have port alu_idx  out  1  index for alu_add_req: 0 = X, 1 = Y.
REQ-012 SHALL have ports start_ack, done, busy, bad_mode  out  1 each.

Function
REQ-013 SHALL increment q every fclk, wrapping 3 -> 0; the edge at which q == 3 is the step boundary.
REQ-014 SHALL use source codes: high 101 = PCH, 110 = latch A, 010 = page 01, 000 = page 00; low 101 = PCL, 110 = latch B, 010 = SP, 011 = ALU.
REQ-015 SHALL, in IDLE, drive hmode 101 / lmode 101 with busy = 0.
REQ-016 SHALL sample start only at a step boundary in IDLE, or in the last step of a sequence. It SHALL pulse start_ack during that q == 3 fclk, and step 0 select codes SHALL appear from the following q == 0.
REQ-017 SHALL define the step sequences (step: high/low; strobes) per amode:
- 0 FETCH: s0 101/101 pc_inc.
- 1 ZP: s0 101/101 pc_inc, latch_b_en; s1 000/110.
- 2 ZPX: s0 as ZP; s1 000/011 alu_add_req, alu_idx = 0.
- 3 ABS: s0 101/101 pc_inc, latch_b_en; s1 101/101 pc_inc, latch_a_en; s2 110/110.
- 4 ABSX: s0, s1 as ABS; s2 110/011 alu_add_req, alu_idx = 0.
- 5 ABSY: as ABSX with alu_idx = 1.
- 6 STACK: s0 010/010.
REQ-018 SHALL treat amode 7 as illegal: start_ack and bad_mode pulse, and the block stays IDLE with no strobe and no done.
REQ-019 SHALL hold select codes constant for all 4 fclk of a step.
REQ-020 SHALL assert the step strobes only during q == 3 of that step, for exactly one fclk.
REQ-021 SHALL pulse done during q == 3 of the last step; busy SHALL be 1 from step 0 through the last step.
REQ-022 SHALL, when rdy = 0 at q == 3: suppress strobes, done and start_ack; repeat the current step (q keeps counting); resume when rdy = 1 at a later q == 3.
REQ-023 SHALL accept start and amode captured at the boundary; changes to them mid-sequence SHALL be ignored.
REQ-024 SHALL, when start is coincident with the last step boundary (rdy = 1), begin the new sequence with no IDLE cycle.

Reset
REQ-025 SHALL, while resb = 0 at a rising fclk, set: q = 0; state IDLE; hmode/lmode 101/101; all strobes, start_ack, done, bad_mode, busy = 0; alu_idx = 0.
REQ-026 SHALL abort any sequence in progress on reset with no done, and accept start no earlier than the first q == 3 after release.

Verification
REQ-027 Reset release, no start -> q cycles 0,1,2,3,0; phi2 = 0,0,1,1; selects stay 101/101; busy = 0.
REQ-028 start, amode = 3 at boundary -> start_ack; then 3 steps 101/101, 101/101, 110/110; pc_inc at s0 and s1 q3; latch_b_en at s0; latch_a_en at s1; done at s2 q3.
REQ-029 amode = 4, rdy = 0 over s2's q3 -> s2 repeats with 110/011 held; no alu_add_req or done until the first q3 with rdy = 1; then one alu_add_req (alu_idx 0) and done.
REQ-030 amode = 6 followed back-to-back by amode = 0 -> 010/010 for one step; done coincides with start_ack; next step is 101/101 with pc_inc.
REQ-031 amode = 7 -> bad_mode and start_ack pulse; busy stays 0; selects stay 101/101.
REQ-032 resb = 0 during s1 of ZPX -> next cycle q = 0, IDLE, 101/101, no done.
